// File: rtl/child_rr_arbiter.sv
// Round-robin arbiter sharing one child datapath among NREQ requesters; 1-cycle req->child_valid, one IDLE bubble per transfer.
// Holds the latched payload while child_ready=0. Optional CHILD_ARB_LOCK_EN adds a lock port that keeps the pointer on the owner.
module child_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
`ifdef CHILD_ARB_LOCK_EN
    input  logic [NREQ-1:0]         lock,
`endif
    output logic [NREQ-1:0]         gnt,
    output logic                    child_valid,
    input  logic                    child_ready,
    output logic [WIDTH-1:0]        child_data,
    output logic [15:0]             xfer_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              found;
    logic [PW-1:0]     win_idx;
    logic              advance;

    // First set request scanning upward from ptr, wrapping modulo NREQ.
    always_comb begin
        int            idx;
        logic [PW-1:0] cand;
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = PW'(idx);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

`ifdef CHILD_ARB_LOCK_EN
    assign advance = ~lock[owner_q];
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    owner_d = win_idx;
                    gnt_d   = NREQ'(1) << win_idx;
                    valid_d = 1'b1;
                    data_d  = req_data[int'(win_idx)*WIDTH +: WIDTH];
                end
            end
            BUSY: begin
                if (child_ready) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    // A locked owner keeps the pointer so it wins again while still requesting.
                    if (!advance)
                        ptr_d = owner_q;
                    else if (owner_q == PW'(NREQ-1))
                        ptr_d = '0;
                    else
                        ptr_d = owner_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign child_valid = valid_q;
    assign child_data  = data_q;
    assign xfer_cnt    = cnt_q;

endmodule
